// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_pkg;

    localparam int DMEM_ADDR_W  = 8;
    localparam int DMEM_MAX_LEN = 8;

    // Scalar addresses with any of these bits set belong to the peripheral window
    localparam logic [15:0] PERI_MASK = 16'hFF00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAL = 2'd1,
        ST_VEC  = 2'd2
    } state_t;

    typedef enum logic {
        GNT_SCAL = 1'b0,
        GNT_VEC  = 1'b1
    } gnt_t;

    function automatic logic [3:0] clamp_len(input logic [3:0] len, input logic [3:0] max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/vec_addr_gen.sv
// rtl/vec_addr_gen.sv - element index counter and strided address generator
module vec_addr_gen #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              step,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] stride,
    input  logic [3:0]        len,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [3:0] idx_q;

    always_ff @(posedge clk) begin
        if (rst || start) begin
            idx_q <= '0;
        end else if (step) begin
            idx_q <= last ? 4'd0 : idx_q + 4'd1;
        end
    end

    // Truncation to ADDR_W bits gives the wrap-around addressing for free
    assign addr = base + (ADDR_W'(idx_q) * stride);
    assign last = (idx_q == (len - 4'd1));

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - scalar/vector arbiter in front of the data SRAM and peripheral bus
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = DMEM_ADDR_W,
    parameter int MAX_LEN = DMEM_MAX_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_req,
    input  logic              s_we,
    input  logic [31:0]       s_addr,
    input  logic [31:0]       s_wdata,
    output logic              s_gnt,
    output logic              s_rvalid,
    output logic [31:0]       s_rdata,
    input  logic              v_req,
    input  logic              v_we,
    input  logic [ADDR_W-1:0] v_base,
    input  logic [ADDR_W-1:0] v_stride,
    input  logic [3:0]        v_len,
    input  logic [31:0]       v_wdata,
    output logic              v_wready,
    output logic              v_rvalid,
    output logic [31:0]       v_rdata,
    output logic              v_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en_wr,
    output logic [31:0]       mem_in,
    input  logic [31:0]       mem_out,
    output logic              peri_web,
    output logic [15:0]       peri_addr,
    output logic [15:0]       peri_datao
);

    localparam logic [3:0] MAX_LEN_L = 4'(MAX_LEN);

    state_t state_q, state_d;
    gnt_t   last_gnt_q;

    logic        s_we_q;
    logic [15:0] s_addr_q;
    logic [31:0] s_wdata_q;
    logic        s_peri_q;
    logic        s_rv_q;

    logic              v_we_q;
    logic [ADDR_W-1:0] v_base_q;
    logic [ADDR_W-1:0] v_stride_q;
    logic [3:0]        v_len_q;
    logic              v_rv_q;
    logic              v_done_q;

    logic              accept_s;
    logic              accept_v;
    logic [3:0]        v_len_clamped;
    logic [ADDR_W-1:0] vec_addr;
    logic              vec_last;

    logic unused_s_addr_hi;
    assign unused_s_addr_hi = ^s_addr[31:16];

    assign v_len_clamped = clamp_len(v_len, MAX_LEN_L);

    vec_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_vec_addr_gen (
        .clk    (clk),
        .rst    (rst),
        .start  (accept_v),
        .step   (state_q == ST_VEC),
        .base   (v_base_q),
        .stride (v_stride_q),
        .len    (v_len_q),
        .addr   (vec_addr),
        .last   (vec_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            last_gnt_q <= GNT_VEC;
            s_we_q     <= 1'b0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            s_peri_q   <= 1'b0;
            s_rv_q     <= 1'b0;
            v_we_q     <= 1'b0;
            v_base_q   <= '0;
            v_stride_q <= '0;
            v_len_q    <= '0;
            v_rv_q     <= 1'b0;
            v_done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_rv_q   <= (state_q == ST_SCAL) && !s_we_q;
            v_rv_q   <= (state_q == ST_VEC) && !v_we_q;
            v_done_q <= (accept_v && (v_len_clamped == 4'd0)) ||
                        ((state_q == ST_VEC) && vec_last);
            if (accept_s) begin
                last_gnt_q <= GNT_SCAL;
                s_we_q     <= s_we;
                s_addr_q   <= s_addr[15:0];
                s_wdata_q  <= s_wdata;
                s_peri_q   <= (s_addr[15:0] & PERI_MASK) != 16'h0000;
            end
            if (accept_v) begin
                last_gnt_q <= GNT_VEC;
                v_we_q     <= v_we;
                v_base_q   <= v_base;
                v_stride_q <= v_stride;
                v_len_q    <= v_len_clamped;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        accept_s = 1'b0;
        accept_v = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s_req && (!v_req || (last_gnt_q == GNT_VEC))) begin
                    accept_s = 1'b1;
                    state_d  = ST_SCAL;
                end else if (v_req) begin
                    accept_v = 1'b1;
                    // A zero-length burst only needs the done pulse, never the VEC state
                    state_d  = (v_len_clamped == 4'd0) ? ST_IDLE : ST_VEC;
                end
            end
            ST_SCAL: state_d = ST_IDLE;
            ST_VEC:  state_d = vec_last ? ST_IDLE : ST_VEC;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s_gnt      = 1'b0;
        v_wready   = 1'b0;
        mem_addr   = '0;
        mem_en_wr  = 1'b1;
        mem_in     = '0;
        peri_web   = 1'b1;
        peri_addr  = '0;
        peri_datao = '0;
        case (state_q)
            ST_SCAL: begin
                s_gnt = 1'b1;
                if (!s_peri_q) begin
                    mem_addr  = s_addr_q[ADDR_W-1:0];
                    mem_en_wr = ~s_we_q;
                    mem_in    = s_wdata_q;
                end else if (s_we_q) begin
                    peri_web   = 1'b0;
                    peri_addr  = s_addr_q;
                    peri_datao = s_wdata_q[15:0];
                end
            end
            ST_VEC: begin
                mem_addr = vec_addr;
                if (v_we_q) begin
                    mem_en_wr = 1'b0;
                    mem_in    = v_wdata;
                    v_wready  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Peripheral reads have no data path back, so they return zero
    assign s_rvalid = s_rv_q;
    assign s_rdata  = (s_rv_q && !s_peri_q) ? mem_out : 32'h0;
    assign v_rvalid = v_rv_q;
    assign v_rdata  = v_rv_q ? mem_out : 32'h0;
    assign v_done   = v_done_q;

endmodule
